// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// the bubble instruction and the default reset PC.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one request in flight
// to instruction memory and feeds decode, buffering one word under back-pressure.
//
// state    | meaning
// FETCH    | request at pc outstanding; a response is offered straight to decode
// HOLD     | decode stalled on a fetched word; word held in hold_instr, no request
// DRAIN    | redirect seen mid-request; wait out the old response, then go to pending_pc
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          PC_INC   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        d_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc,
  output logic        f_stall,
  output logic        f_flush
);

  localparam logic [31:0] PC_STEP = 32'(PC_INC);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  hold_instr;
  logic [31:0]  pending_pc;
  logic [31:0]  pc_next;

  // Modulo-2^32 increment; the top word wraps to address zero.
  assign pc_next = pc + PC_STEP;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      hold_instr <= NOP_INSTR;
      pending_pc <= '0;
    end else if (redirect_valid) begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            pc <= redirect_pc;
          end else begin
            pending_pc <= redirect_pc;
            state      <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          pc    <= redirect_pc;
          state <= ST_FETCH;
        end
        ST_DRAIN: begin
          pending_pc <= redirect_pc;
          if (imem_ready) begin
            pc    <= redirect_pc;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            if (d_stall) begin
              hold_instr <= imem_rdata;
              state      <= ST_HOLD;
            end else begin
              pc <= pc_next;
            end
          end
        end
        ST_HOLD: begin
          if (!d_stall) begin
            pc    <= pc_next;
            state <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (imem_ready) begin
            pc    <= pending_pc;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Outputs follow the memory response within the cycle so a ready-on-request
  // memory sustains one instruction per cycle.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    f_instr   = NOP_INSTR;
    f_pc      = pc;
    f_stall   = 1'b1;
    f_flush   = 1'b0;
    if (reset) begin
      f_pc = '0;
    end else begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          f_instr  = imem_rdata;
          f_stall  = !imem_ready;
        end
        ST_HOLD: begin
          f_instr = hold_instr;
          f_stall = 1'b0;
        end
        ST_DRAIN: begin
          imem_req = 1'b1;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
      if (redirect_valid) begin
        f_flush = 1'b1;
        f_stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        d_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_stall;
  logic        f_flush;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .d_stall        (d_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .f_instr        (f_instr),
    .f_pc           (f_pc),
    .f_stall        (f_stall),
    .f_flush        (f_flush)
  );

  always #5 clock = ~clock;

  // Transaction-level model: the next address to fetch, an optional buffered
  // word awaiting decode, and an optional "discard the in-flight reply, then
  // jump" target.
  logic [31:0] m_pc        = RST_PC;
  bit          m_have_word = 1'b0;
  logic [31:0] m_word      = '0;
  bit          m_discard   = 1'b0;
  logic [31:0] m_target    = '0;

  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_pc = RST_PC; m_have_word = 0; m_discard = 0;
    end else if (redirect_valid) begin
      if (m_have_word) begin
        m_have_word = 0; m_pc = redirect_pc;
      end else if (m_discard) begin
        m_target = redirect_pc;
        if (imem_ready) begin m_discard = 0; m_pc = redirect_pc; end
      end else if (imem_ready) begin
        m_pc = redirect_pc;
      end else begin
        m_discard = 1; m_target = redirect_pc;
      end
    end else if (m_have_word) begin
      if (!d_stall) begin m_have_word = 0; m_pc = m_pc + 32'd4; end
    end else if (m_discard) begin
      if (imem_ready) begin m_discard = 0; m_pc = m_target; end
    end else if (imem_ready) begin
      if (d_stall) begin m_have_word = 1; m_word = imem_rdata; end
      else m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      logic e_req, e_stall, e_flush;
      logic [31:0] e_instr, e_pc;
      e_flush = redirect_valid && !reset;
      if (reset) begin
        e_req = 0; e_stall = 1; e_instr = '0; e_pc = '0;
      end else if (m_have_word) begin
        e_req = 0; e_stall = redirect_valid; e_instr = m_word; e_pc = m_pc;
      end else if (m_discard) begin
        e_req = 1; e_stall = 1; e_instr = '0; e_pc = m_pc;
      end else begin
        e_req = 1; e_stall = redirect_valid || !imem_ready; e_instr = imem_rdata; e_pc = m_pc;
      end
      check("imem_req", 32'(imem_req), 32'(e_req));
      check("f_stall",  32'(f_stall),  32'(e_stall));
      check("f_flush",  32'(f_flush),  32'(e_flush));
      if (e_req) check("imem_addr", imem_addr, m_pc);
      if (!e_stall) begin
        check("f_instr", f_instr, e_instr);
        check("f_pc",    f_pc,    e_pc);
      end
      if (prev_wait && !reset) check("addr_stable", imem_addr, prev_addr);
      prev_wait = imem_req && !imem_ready && !reset;
      prev_addr = imem_addr;
    end
  end

  task automatic cyc(input bit rst, input bit dst, input bit rv, input logic [31:0] rpc,
                     input bit rdy, input logic [31:0] rd);
    @(posedge clock);
    #1;
    reset = rst; d_stall = dst; redirect_valid = rv; redirect_pc = rpc;
    imem_ready = rdy; imem_rdata = rd;
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1; d_stall = 0; redirect_valid = 0; redirect_pc = '0;
    imem_ready = 0; imem_rdata = '0;

    cyc(1, 0, 0, 0, 0, 0);
    chk_en = 1;
    cyc(1, 0, 0, 0, 1, 32'h1111);
    check("rst_req", 32'(imem_req), 0);
    check("rst_stall", 32'(f_stall), 1);

    // streaming, then a 3-cycle memory wait at 0x1004
    cyc(0, 0, 0, 0, 1, 32'hA0);
    check("s1_addr", imem_addr, 32'h1000);
    check("s1_instr", f_instr, 32'hA0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 32'hDEAD);
      check("s2_addr", imem_addr, 32'h1004);
      check("s2_stall", 32'(f_stall), 1);
    end
    cyc(0, 0, 0, 0, 1, 32'hA1);
    check("s2_instr", f_instr, 32'hA1);
    check("s2_pc", f_pc, 32'h1004);

    // decode back-pressure at 0x1008
    cyc(0, 1, 0, 0, 1, 32'hA2);
    check("s3_addr", imem_addr, 32'h1008);
    cyc(0, 1, 0, 0, 0, 32'hDEAD);
    check("s3_req", 32'(imem_req), 0);
    check("s3_hold", f_instr, 32'hA2);
    cyc(0, 0, 0, 0, 0, 32'hDEAD);
    check("s3_hold2", f_instr, 32'hA2);
    cyc(0, 0, 0, 0, 1, 32'hA3);
    check("s3_next", imem_addr, 32'h100C);

    // redirect mid-request at 0x1010
    cyc(0, 0, 1, 32'h2000, 0, 0);
    check("s4_flush", 32'(f_flush), 1);
    check("s4_addr", imem_addr, 32'h1010);
    cyc(0, 0, 0, 0, 0, 0);
    check("s4_held", imem_addr, 32'h1010);
    cyc(0, 0, 0, 0, 1, 32'hBAD);
    check("s4_discard", 32'(f_stall), 1);
    cyc(0, 0, 0, 0, 1, 32'hA4);
    check("s4_target", imem_addr, 32'h2000);

    // two redirects while draining
    cyc(0, 0, 1, 32'h3000, 0, 0);
    cyc(0, 0, 1, 32'h4000, 0, 0);
    check("s5_addr", imem_addr, 32'h2004);
    cyc(0, 0, 0, 0, 1, 32'hBAD);
    cyc(0, 0, 0, 0, 1, 32'hA5);
    check("s5_target", imem_addr, 32'h4000);

    // reset out of HOLD and out of DRAIN
    cyc(0, 1, 0, 0, 1, 32'hA6);
    cyc(1, 1, 0, 0, 0, 0);
    check("s6_rst_req", 32'(imem_req), 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("s6_addr", imem_addr, 32'h1000);
    check("s6_req", 32'(imem_req), 1);
    cyc(0, 0, 1, 32'h5000, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'hBAD);
    cyc(0, 0, 0, 0, 1, 32'hA7);
    check("s6_addr2", imem_addr, 32'h1000);
    check("s6_instr", f_instr, 32'hA7);

    // PC wrap at the top of the address space
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1, 0);
    cyc(0, 0, 0, 0, 1, 32'hA8);
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1, 32'hA9);
    check("wrap_zero", imem_addr, 32'h0);

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : {$urandom() & 32'hFFFF_FFFC};
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
          rpc, $urandom_range(0, 1) == 1, $urandom());
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
